// File: rtl/div_pkg.sv
// div_pkg: shared constants, state encoding and adder cell
// for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 7;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // iteration counter width for an arbitrary operand width
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // one-bit full adder cell, returns {carry_out, sum}
    function automatic logic [1:0] full_add(
        input logic a,
        input logic b,
        input logic ci
    );
        logic s;
        logic co;
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
        return {co, s};
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// div_trial_sub: ripple a - b built from full adder cells
// (b inverted, carry-in 1); borrow is the inverted carry out.
module div_trial_sub
    import div_pkg::*;
#(
    parameter int N = DIV_WIDTH + 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign {carry[i+1], diff[i]} = full_add(a[i], ~b[i], carry[i]);
    end

    assign borrow = ~carry[N];

endmodule

// File: rtl/div7_seq.sv
// div7_seq: sequential restoring divider, one quotient bit per clock.
// Optional DIV_DBZ_FLAG_EN: zero divisor skips CALC and raises div_by_zero.
module div7_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef DIV_DBZ_FLAG_EN
    ,
    output logic             div_by_zero
`endif
);

    localparam int CW = cnt_width(WIDTH);

    div_state_e state;
    div_state_e next_state;

    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic             zero_div;
    logic             unused_diff_msb;

`ifdef DIV_DBZ_FLAG_EN
    assign zero_div = (divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    // keep the bit shifted out of R so large divisors stay exact
    assign r_sh = {r, q[WIDTH-1]};

    div_trial_sub #(
        .N(WIDTH + 1)
    ) u_sub (
        .a     (r_sh),
        .b     ({1'b0, d}),
        .diff  (diff),
        .borrow(borrow)
    );

    // a successful trial always fits back into WIDTH bits
    assign unused_diff_msb = diff[WIDTH];
    assign r_next = borrow ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_next = {q[WIDTH-2:0], ~borrow};

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = zero_div ? DONE : CALC;
            CALC:    if (cnt == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // working registers, counter and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r         <= '0;
            q         <= '0;
            d         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_DBZ_FLAG_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        r   <= '0;
                        q   <= dividend;
                        d   <= divisor;
                        cnt <= CW'(WIDTH - 1);
`ifdef DIV_DBZ_FLAG_EN
                        if (zero_div) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
`endif
                    end
                end
                CALC: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        quotient  <= q_next;
                        remainder <= r_next;
`ifdef DIV_DBZ_FLAG_EN
                        div_by_zero <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div7_seq.sv
// tb_div7_seq: directed table of divisions plus hand-written
// sequences for ignored start, back-to-back and reset corners.
module tb_div7_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] dividend;
    logic [6:0] divisor;
    logic       busy;
    logic       done;
    logic [6:0] quotient;
    logic [6:0] remainder;
    logic       dbz;

    int checks = 0;
    int errors = 0;

`ifdef DIV_DBZ_FLAG_EN
    localparam bit DBZ_EN = 1'b1;
`else
    localparam bit DBZ_EN = 1'b0;
    assign dbz = 1'b0;
`endif

    div7_seq dut (
        .clk      (clk),
`ifdef DIV_DBZ_FLAG_EN
        .div_by_zero(dbz),
`endif
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] a;
        logic [6:0] b;
        logic [6:0] q;
        logic [6:0] r;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start one division in the current IDLE cycle; inj>0 fires a
    // stray 9/2 start at that cycle, rst>0 asserts reset at that cycle
    task automatic run_op(input logic [6:0] a, input logic [6:0] b,
                          input logic [6:0] eq, input logic [6:0] er,
                          input int lat, input int inj, input int rst);
        int cyc;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 7'($urandom);
        divisor  = 7'($urandom);
        cyc = 1;
        while (cyc <= 20) begin
            if (done === 1'b1) break;
            chk("busy_calc", {31'd0, busy}, 1);
            start = (cyc == inj);
            if (cyc == inj) begin
                dividend = 7'd9;
                divisor  = 7'd2;
            end
            if (cyc == rst) reset = 1'b1;
            tick();
            start = 1'b0;
            cyc++;
            if (rst != 0 && cyc == rst + 1) begin
                reset = 1'b0;
                chk("rst_busy", {31'd0, busy}, 0);
                chk("rst_done", {31'd0, done}, 0);
                chk("rst_quot", {25'd0, quotient}, 0);
                chk("rst_rem", {25'd0, remainder}, 0);
                tick();
                chk("rst_no_done", {31'd0, done}, 0);
                return;
            end
        end
        chk("done_cycle", cyc, lat);
        chk("busy_done", {31'd0, busy}, 1);
        chk("quotient", {25'd0, quotient}, {25'd0, eq});
        chk("remainder", {25'd0, remainder}, {25'd0, er});
        if (DBZ_EN) chk("dbz_flag", {31'd0, dbz}, {31'd0, b == 7'd0});
        tick();
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_done", {31'd0, done}, 0);
        chk("hold_quot", {25'd0, quotient}, {25'd0, eq});
    endtask

    initial begin
        vecs[0] = '{7'd100, 7'd7,   7'd14,  7'd2};
        vecs[1] = '{7'd127, 7'd1,   7'd127, 7'd0};
        vecs[2] = '{7'd5,   7'd9,   7'd0,   7'd5};
        vecs[3] = '{7'd126, 7'd126, 7'd1,   7'd0};
        vecs[4] = '{7'd45,  7'd0,   7'd127, 7'd45};
        vecs[5] = '{7'd10,  7'd3,   7'd3,   7'd1};
        vecs[6] = '{7'd0,   7'd5,   7'd0,   7'd0};
        vecs[7] = '{7'd127, 7'd127, 7'd1,   7'd0};
        vecs[8] = '{7'd127, 7'd100, 7'd1,   7'd27};
        vecs[9] = '{7'd9,   7'd2,   7'd4,   7'd1};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_quot", {25'd0, quotient}, 0);
        chk("reset_rem", {25'd0, remainder}, 0);
        chk("reset_dbz", {31'd0, dbz}, 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                   (DBZ_EN && vecs[i].b == 7'd0) ? 1 : 8, 0, 0);
        end

        run_op(7'd100, 7'd7, 7'd14, 7'd2, 8, 3, 0);
        run_op(7'd9, 7'd2, 7'd4, 7'd1, 8, 0, 0);
        run_op(7'd100, 7'd7, 7'd0, 7'd0, 8, 0, 4);

        reset    = 1'b1;
        start    = 1'b1;
        dividend = 7'd50;
        divisor  = 7'd5;
        tick();
        chk("rst_start_busy", {31'd0, busy}, 0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("rst_start_idle", {31'd0, busy}, 0);
        chk("rst_start_quot", {25'd0, quotient}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
